// File: rtl/odot_pkg.sv
// Shared types and constants for the element-wise (Hadamard) product sequencer.
// Holds default fixed-point format, FSM state encoding and Q8.8 saturation limits.
package odot_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;

    localparam logic [DATA_WIDTH_DEF-1:0] SAT_MAX_DEF = 16'h7FFF;
    localparam logic [DATA_WIDTH_DEF-1:0] SAT_MIN_DEF = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/odot_sequencer_if.sv
// Control, operand-read and result-write signals of the Hadamard sequencer.
// The master side is the sequencer; the slave side is memory plus controller.
interface odot_sequencer_if
    import odot_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = 4
);

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start, a_rdata, b_rdata,
        output busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, a_rdata, b_rdata,
        input  busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full product, floor shift by the
// fraction width, then saturation to the data width with an overflow flag.
module fxp_mul_sat #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] SAT_HI = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shift_s;

    // Product, arithmetic shift (floor toward minus infinity) and clamp.
    always_comb begin
        prod_s  = PW'(a) * PW'(b);
        shift_s = prod_s >>> FRACT_WIDTH;
        if (shift_s > SAT_HI) begin
            y   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            ovf = 1'b1;
        end else if (shift_s < SAT_LO) begin
            y   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
            ovf = 1'b1;
        end else begin
            y   = shift_s[DATA_WIDTH-1:0];
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/odot_sequencer.sv
// Walks an H x W operand pair in row-major order and writes Y = A odot B,
// one element per cycle, with a two-stage read/multiply pipeline.
module odot_sequencer
    import odot_pkg::*;
#(
    parameter int H           = 4,
    parameter int W           = 3,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ($clog2(H * W) > 0) ? $clog2(H * W) : 1
) (
    input logic              clk,
    input logic              rst_n,
    odot_sequencer_if.master bus
);

    localparam int N = H * W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t state_r, next_state_s;

    logic                  rd_en_r,    rd_en_s;
    logic [ADDR_WIDTH-1:0] rd_addr_r,  rd_addr_s;
    logic                  op_valid_r, op_valid_s;
    logic [ADDR_WIDTH-1:0] op_addr_r,  op_addr_s;
    logic                  wr_en_r,    wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r,  wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_r,  wr_data_s;
    logic                  busy_r,     busy_s;
    logic                  done_r,     done_s;
    logic                  ovf_r,      ovf_s;

    logic [DATA_WIDTH-1:0] mul_y_s;
    logic                  mul_ovf_s;

    // Operands arrive combinationally the cycle after rd_en; the result register is the write stage.
    fxp_mul_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_mul (
        .a   (bus.a_rdata),
        .b   (bus.b_rdata),
        .y   (mul_y_s),
        .ovf (mul_ovf_s)
    );

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rd_en_r    <= 1'b0;
            rd_addr_r  <= ADDR_ZERO;
            op_valid_r <= 1'b0;
            op_addr_r  <= ADDR_ZERO;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_ZERO;
            wr_data_r  <= DATA_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rd_en_r    <= rd_en_s;
            rd_addr_r  <= rd_addr_s;
            op_valid_r <= op_valid_s;
            op_addr_r  <= op_addr_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            ovf_r      <= ovf_s;
        end
    end

    // Next-state logic; DRAIN exits once the last write is on the bus.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_state_s = ST_RUN;
                else           next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (rd_addr_r == LAST_ADDR) next_state_s = ST_DRAIN;
                else                        next_state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (wr_en_r && (wr_addr_r == LAST_ADDR)) next_state_s = ST_DONE;
                else                                     next_state_s = ST_DRAIN;
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        rd_en_s    = (next_state_s == ST_RUN);
        rd_addr_s  = ADDR_ZERO;
        op_valid_s = rd_en_r;
        op_addr_s  = rd_addr_r;
        wr_en_s    = op_valid_r;
        wr_addr_s  = ADDR_ZERO;
        wr_data_s  = DATA_ZERO;
        busy_s     = (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN);
        done_s     = (next_state_s == ST_DONE);
        ovf_s      = ovf_r;

        if ((next_state_s == ST_RUN) && (state_r == ST_RUN)) begin
            rd_addr_s = rd_addr_r + ADDR_WIDTH'(1);
        end else begin
            rd_addr_s = ADDR_ZERO;
        end

        if (op_valid_r) begin
            wr_addr_s = op_addr_r;
            wr_data_s = mul_y_s;
        end else begin
            wr_addr_s = ADDR_ZERO;
            wr_data_s = DATA_ZERO;
        end

        // An accepted start opens a fresh pass, so the sticky flag restarts there.
        if ((state_r == ST_IDLE) && bus.start) begin
            ovf_s = 1'b0;
        end else if (op_valid_r && mul_ovf_s) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = ovf_r;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = rd_addr_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_odot_sequencer.sv
// Scoreboard bench for odot_sequencer (H=4, W=3, Q8.8): expected writes are queued
// at start and popped by a write monitor; each scenario checks timing and flags.
module tb_odot_sequencer;
    import odot_pkg::*;

    localparam int N = 12;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    exp_t        sb_q[$];
    logic [15:0] a_mem [N];
    logic [15:0] b_mem [N];
    logic [15:0] exp_y [N];

    odot_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    odot_sequencer #(.H(4), .W(3), .DATA_WIDTH(16), .FRACT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memory: one-cycle latency, garbage when not read.
    initial begin
        logic       pend_en;
        logic [3:0] pend_addr;
        bus.a_rdata = 16'h0000;
        bus.b_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            pend_en   = bus.rd_en;
            pend_addr = bus.rd_addr;
            @(posedge clk);
            #1;
            if (pend_en === 1'b1 && pend_addr < 4'd12) begin
                bus.a_rdata = a_mem[pend_addr];
                bus.b_rdata = b_mem[pend_addr];
            end else begin
                bus.a_rdata = 16'($urandom);
                bus.b_rdata = 16'($urandom);
            end
        end
    end

    // Write monitor / scoreboard plus idle-zero checks on the address and data buses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%0d data=%h want no write", bus.wr_addr, bus.wr_data);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data || cyc !== e.cyc) begin
                        bad++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 bus.wr_addr, bus.wr_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end else begin
                total++;
                if (bus.wr_addr !== 4'd0 || bus.wr_data !== 16'h0000) begin
                    bad++;
                    $display("FAIL idle_wr_bus got addr=%0d data=%h want 0/0000", bus.wr_addr, bus.wr_data);
                end
            end
            if (bus.rd_en !== 1'b1) begin
                total++;
                if (bus.rd_addr !== 4'd0) begin
                    bad++;
                    $display("FAIL idle_rd_addr got=%0d want=0", bus.rd_addr);
                end
            end
        end
    end

    function automatic logic [15:0] ref_y(input logic [15:0] a, input logic [15:0] b, output bit sat);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = (p - (((p % 256) + 256) % 256)) / 256;
        sat = 1'b0;
        if (s > 32767) begin
            sat = 1'b1;
            ref_y = SAT_MAX_DEF;
        end else if (s < -32768) begin
            sat = 1'b1;
            ref_y = SAT_MIN_DEF;
        end else begin
            ref_y = 16'(s);
        end
    endfunction

    // Runs one pass from the current negedge (cycle 0); bus observations returned for the caller to judge.
    task automatic do_pass(input bit repulse, output int done_at, output int n_done,
                           output int bad_busy, output int bad_rd, output logic ovf_c1, output logic ovf_end);
        int  t0;
        logic exp_busy;
        t0 = cyc;
        for (int k = 0; k < N; k++) sb_q.push_back('{4'(k), exp_y[k], t0 + k + 3});
        bus.start = 1'b1;
        done_at = -1; n_done = 0; bad_busy = 0; bad_rd = 0; ovf_c1 = 1'bx;
        for (int j = 1; j <= N + 4; j++) begin
            @(negedge clk);
            bus.start = (repulse && (j == 4 || j == 15)) ? 1'b1 : 1'b0;
            exp_busy = (j <= N + 2);
            if (bus.busy !== exp_busy) bad_busy++;
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = j;
            end
            if (j <= N) begin
                if (bus.rd_en !== 1'b1 || bus.rd_addr !== 4'(j - 1)) bad_rd++;
            end else begin
                if (bus.rd_en !== 1'b0) bad_rd++;
            end
            if (j == 1) ovf_c1 = bus.ovf;
        end
        ovf_end = bus.ovf;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int bz;
        bz = 0;
        rst_n = 1'b0;
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({bus.busy, bus.done, bus.ovf, bus.rd_en, bus.wr_en} !== 5'b0 ||
                bus.rd_addr !== 4'd0 || bus.wr_addr !== 4'd0 || bus.wr_data !== 16'h0000) bz++;
        end
        total++; if (bz !== 0) begin bad++; $display("FAIL reset_outputs got=%0d nonzero cycles want=0", bz); end
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored got busy=%b want=0", bus.busy); end
    endtask

    task automatic test_basic();
        int d, nd, bb, br; logic o1, oe;
        for (int k = 0; k < N; k++) begin a_mem[k] = 16'h0040; b_mem[k] = 16'h0040; exp_y[k] = 16'h0010; end
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (d !== 15) begin bad++; $display("FAIL basic_done_cycle got=%0d want=15", d); end
        total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy got=%0d bad cycles want=0", bb); end
        total++; if (br !== 0) begin bad++; $display("FAIL basic_rd_seq got=%0d bad cycles want=0", br); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", oe); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL basic_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_alternate();
        int d, nd, bb, br; logic o1, oe;
        for (int k = 0; k < N; k++) begin
            a_mem[k] = (k % 2 == 1) ? 16'hFFC0 : 16'h00C0;
            b_mem[k] = 16'h0040;
            exp_y[k] = (k % 2 == 1) ? 16'hFFF0 : 16'h0030;
        end
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (d !== 15 || nd !== 1) begin bad++; $display("FAIL alt_done got at=%0d n=%0d want 15/1", d, nd); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL alt_ovf got=%b want=0", oe); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL alt_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_saturate();
        int d, nd, bb, br; logic o1, oe;
        for (int k = 0; k < N; k++) begin a_mem[k] = 16'h0000; b_mem[k] = 16'h0000; exp_y[k] = 16'h0000; end
        a_mem[5] = 16'h7FFF; b_mem[5] = 16'h7FFF; exp_y[5] = 16'h7FFF;
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (oe !== 1'b1) begin bad++; $display("FAIL sat_pos_ovf got=%b want=1", oe); end
        total++; if (d !== 15) begin bad++; $display("FAIL sat_pos_done got=%0d want=15", d); end
        a_mem[5] = 16'h8000; exp_y[5] = 16'h8000;
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (o1 !== 1'b0) begin bad++; $display("FAIL sat_ovf_cleared_at_start got=%b want=0", o1); end
        total++; if (oe !== 1'b1) begin bad++; $display("FAIL sat_neg_ovf got=%b want=1", oe); end
        a_mem[5] = 16'h0000; exp_y[5] = 16'h0000;
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL sat_ovf_next_pass got=%b want=0", oe); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL sat_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_trunc();
        int d, nd, bb, br; logic o1, oe;
        for (int k = 0; k < N; k++) begin a_mem[k] = 16'h0000; b_mem[k] = 16'h0001; exp_y[k] = 16'h0000; end
        a_mem[0] = 16'h0002; exp_y[0] = 16'h0000;
        a_mem[1] = 16'hFFFE; exp_y[1] = 16'hFFFF;
        a_mem[2] = 16'hFF00; exp_y[2] = 16'hFFFF;
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL trunc_ovf got=%b want=0", oe); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL trunc_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_ignore_start();
        int d, nd, bb, br; logic o1, oe;
        for (int k = 0; k < N; k++) begin a_mem[k] = 16'(k * 256); b_mem[k] = 16'h0100; exp_y[k] = 16'(k * 256); end
        do_pass(1'b1, d, nd, bb, br, o1, oe);
        total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL ignore_busy got=%0d bad cycles want=0", bb); end
        total++; if (br !== 0) begin bad++; $display("FAIL ignore_rd_seq got=%0d bad cycles want=0", br); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL ignore_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d, nd, bb, br, t0, bz; logic o1, oe;
        bz = 0;
        for (int k = 0; k < N; k++) begin a_mem[k] = 16'h0080; b_mem[k] = 16'(16'h0010 * k); exp_y[k] = 16'(16'h0008 * k); end
        t0 = cyc;
        for (int k = 0; k < 4; k++) sb_q.push_back('{4'(k), exp_y[k], t0 + k + 3});
        bus.start = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            bus.start = (j == 7 || j == 8) ? 1'b1 : 1'b0;
            if (j == 6) rst_n = 1'b0;
            if (j == 10) rst_n = 1'b1;
            if (j >= 7) begin
                if ({bus.busy, bus.done, bus.ovf, bus.rd_en, bus.wr_en} !== 5'b0 ||
                    bus.rd_addr !== 4'd0 || bus.wr_addr !== 4'd0 || bus.wr_data !== 16'h0000) bz++;
            end
        end
        total++; if (bz !== 0) begin bad++; $display("FAIL midreset_outputs got=%0d nonzero cycles want=0", bz); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL midreset_partial_writes got=%0d pending want=0", sb_q.size()); end
        do_pass(1'b0, d, nd, bb, br, o1, oe);
        total++; if (d !== 15 || nd !== 1) begin bad++; $display("FAIL midreset_repass_done got at=%0d n=%0d want 15/1", d, nd); end
        total++; if (br !== 0) begin bad++; $display("FAIL midreset_repass_rd got=%0d bad cycles want=0", br); end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL midreset_repass_writes got=%0d want=0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d, nd, bb, br; logic o1, oe; bit s, any_sat;
        for (int p = 0; p < 2; p++) begin
            any_sat = 1'b0;
            for (int k = 0; k < N; k++) begin
                a_mem[k] = 16'($urandom);
                b_mem[k] = (p == 0) ? 16'($urandom_range(0, 511)) - 16'd256 : 16'($urandom);
                exp_y[k] = ref_y(a_mem[k], b_mem[k], s);
                any_sat |= s;
            end
            do_pass(1'b0, d, nd, bb, br, o1, oe);
            total++; if (d !== 15 || nd !== 1) begin bad++; $display("FAIL b2b_done pass=%0d got at=%0d n=%0d want 15/1", p, d, nd); end
            total++; if (bb !== 0) begin bad++; $display("FAIL b2b_busy pass=%0d got=%0d want=0", p, bb); end
            total++; if (oe !== any_sat) begin bad++; $display("FAIL b2b_ovf pass=%0d got=%b want=%b", p, oe, any_sat); end
        end
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL b2b_missing_writes got=%0d want=0", sb_q.size()); end
    endtask

    initial begin
        cyc = 0;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        test_reset();
        test_basic();
        test_alternate();
        test_saturate();
        test_trunc();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/odot_sequencer.md
ODOT_SEQUENCER -- requirements
Module: odot_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  H, 4, matrix rows
  W, 3, matrix columns
  DATA_WIDTH, 16, signed fixed-point element width
  FRACT_WIDTH, 8, fraction bits
  ADDR_WIDTH, clog2(H*W), element address width
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset, synchronous, active-low
  start  in  1  request one element-wise (Hadamard) pass
  busy  out  1  pass in progress
  done  out  1  one-cycle completion pulse
  ovf  out  1  sticky saturation flag for the current/last pass
  rd_en  out  1  operand read strobe
  rd_addr  out  ADDR_WIDTH  operand element index, row-major (row*W+col)
  a_rdata  in  DATA_WIDTH  element of A, valid the cycle after rd_en
  b_rdata  in  DATA_WIDTH  element of B, valid the cycle after rd_en
  wr_en  out  1  result write strobe
  wr_addr  out  ADDR_WIDTH  result element index
  wr_data  out  DATA_WIDTH  result element Y = A odot B

Function
REQ-003 N = H*W; FSM states: IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE: start=1 at edge E0 -> RUN; ovf cleared at E0; start in any other state ignored.
REQ-005 RUN: cycle k+1 after E0 (k=0..N-1): rd_en=1, rd_addr=k; after rd_addr=N-1 -> DRAIN.
REQ-006 Pipeline: operands captured the cycle after rd_en; product registered one cycle later; wr_en=1, wr_addr=k, wr_data=Y[k] during cycle k+3.
REQ-007 DRAIN: held until the write of index N-1 is issued (cycle N+2), then -> DONE.
REQ-008 DONE: single cycle (cycle N+3); done=1, busy=0, then -> IDLE; a start sampled in DONE is ignored.
REQ-009 busy=1 in cycles 1..N+2 inclusive, 0 otherwise; back-to-back pass earliest start sample is the edge ending cycle N+4.
REQ-010 Arithmetic: p = signed(a)*signed(b), 2*DATA_WIDTH bits; s = p arithmetic-shifted right FRACT_WIDTH (floor toward minus infinity, no rounding).
REQ-011 Saturation: s > 2^(DATA_WIDTH-1)-1 -> max positive; s < -2^(DATA_WIDTH-1) -> min negative; either case sets ovf on the wr_en cycle.
REQ-012 ovf sticky from first saturation until next accepted start or reset; readable after done.
REQ-013 rd_addr, wr_addr, wr_data SHALL hold 0 when their strobes are low.
REQ-014 No backpressure: operand memory returns data in exactly one cycle; writes always accepted.

Reset
REQ-015 rst_n=0 at an edge: state IDLE; busy, done, ovf, rd_en, wr_en, rd_addr, wr_addr, wr_data = 0; pipeline valids cleared.
REQ-016 Reset mid-pass aborts without further rd_en/wr_en/done; first start after rst_n=1 begins a clean pass at index 0.
REQ-017 start with rst_n=0 SHALL be ignored.

Structure
REQ-018 Package odot_pkg SHALL hold DATA_WIDTH/FRACT_WIDTH defaults, state enum, saturation limit constants.
REQ-019 Sub-module fxp_mul_sat (combinational signed multiply, shift, saturate, ovf bit) SHALL be instantiated once, usable by other datapaths.
REQ-020 Implementation size 120-400 RTL lines; single clock domain.

Verification (H=4, W=3, Q8.8)
REQ-021 All A=B=0x0040 (0.25), start -> 12 writes addr 0..11 in cycles 3..14, each 0x0010; done at cycle 15; ovf=0.
REQ-022 A odd idx=0xFFC0 (-0.25), even=0x00C0 (0.75), B=0x0040 -> odd 0xFFF0, even 0x0030.
REQ-023 A=0x7FFF, B=0x7FFF at idx 5, others 0 -> Y[5]=0x7FFF, ovf=1 after done; A=0x8000,B=0x7FFF -> 0x8000; ovf cleared by next start.
REQ-024 Truncation: A=0x0002,B=0x0001 -> 0x0000; A=0xFFFE,B=0x0001 -> 0xFFFF.
REQ-025 start re-pulsed at cycles 4 and 15 -> ignored; exactly 12 writes, one done pulse.
REQ-026 rst_n=0 at cycle 6 -> no further strobes, all outputs 0; new start -> full correct pass from index 0.
